// File: rtl/vgroup_uop_sequencer.sv
// vgroup_uop_sequencer: splits one decoded vector ALU instruction into
// per-register micro-ops when LMUL>1 register grouping is enabled. Each uop
// carries base+idx register indices (mod 32) and its own active element count
// derived from vl. stall_fe holds the front end while a group is issuing.
//
// Optional build macro: VGRP_ALIGN_CHECK_EN
//   defined   -> grouped instructions whose raA/raB/rdest are not multiples
//                of the group size are rejected with an illegal_op pulse.
//   undefined -> no alignment check; misaligned groups wrap modulo 32.
module vgroup_uop_sequencer #(
  parameter int EPR  = 4,
  parameter int VL_W = 6
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [4:0]      raA,
  input  logic [4:0]      raB,
  input  logic [4:0]      rdest,
  input  logic [2:0]      lmul,
  input  logic [VL_W-1:0] vl,
  input  logic            grouping_enable,
  output logic            uop_valid,
  input  logic            uop_ready,
  output logic [4:0]      uop_raA,
  output logic [4:0]      uop_raB,
  output logic [4:0]      uop_rdest,
  output logic [2:0]      uop_idx,
  output logic [VL_W-1:0] uop_vl,
  output logic            uop_last,
  output logic            stall_fe,
  output logic            illegal_op,
  output logic            busy
);

  localparam int SH = $clog2(EPR);
  localparam int CW = VL_W + 3;

  typedef enum logic {IDLE, ISSUE} state_t;

  state_t          state_q, state_d;
  logic [2:0]      cnt_q;
  logic [4:0]      base_a_q, base_b_q, base_d_q;
  logic [3:0]      n_q;
  logic [VL_W-1:0] vl_q;
  logic            illegal_q;

  logic [4:0]      uop_a_q, uop_b_q, uop_d_q;
  logic [2:0]      uop_idx_q;
  logic [VL_W-1:0] uop_vl_q;
  logic            uop_last_q;

  // Decode and group-size computation for the instruction at the input.
  logic [3:0]  l_dec, l_val, n_calc;
  logic [VL_W:0] ceil_full;
  logic        lmul_illegal, misalign, accept, start, fire;

  always_comb begin
    case (lmul[1:0])
      2'b00:   l_dec = 4'd1;
      2'b01:   l_dec = 4'd2;
      2'b10:   l_dec = 4'd4;
      default: l_dec = 4'd8;
    endcase
  end

  assign l_val        = grouping_enable ? l_dec : 4'd1;
  assign lmul_illegal = grouping_enable & lmul[2];
  assign ceil_full    = ({1'b0, vl} + (VL_W+1)'(EPR - 1)) >> SH;
  assign n_calc       = (ceil_full < {{(VL_W-3){1'b0}}, l_val}) ? ceil_full[3:0] : l_val;

`ifdef VGRP_ALIGN_CHECK_EN
  logic [4:0] align_mask;
  assign align_mask = {1'b0, l_dec} - 5'd1;
  assign misalign   = grouping_enable & !lmul[2] & (((raA | raB | rdest) & align_mask) != 5'd0);
`else
  assign misalign   = 1'b0;
`endif

  assign in_ready = (state_q == IDLE);
  assign busy     = (state_q == ISSUE);
  assign accept   = in_valid & in_ready;
  assign start    = accept & !lmul_illegal & !misalign & (n_calc != 4'd0);
  assign fire     = uop_valid & uop_ready;
  assign stall_fe = busy & !(fire & uop_last_q);

  // Next-uop field generation: uop 0 from the inputs on accept, else uop cnt+1
  // from the latched instruction.
  logic [4:0]      src_a, src_b, src_d;
  logic [VL_W-1:0] src_vl;
  logic [3:0]      src_n;
  logic [2:0]      src_idx;
  logic [CW-1:0]   rem;
  logic [VL_W-1:0] nxt_vl;
  logic            nxt_last;

  // NOTE: every signal written in always_comb gets a default first, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    src_a   = base_a_q;
    src_b   = base_b_q;
    src_d   = base_d_q;
    src_vl  = vl_q;
    src_n   = n_q;
    src_idx = cnt_q + 3'd1;
    if (state_q == IDLE) begin
      src_a   = raA;
      src_b   = raB;
      src_d   = rdest;
      src_vl  = vl;
      src_n   = n_calc;
      src_idx = 3'd0;
    end
    rem      = CW'(src_vl) - (CW'(src_idx) << SH);
    nxt_vl   = (rem > CW'(EPR)) ? VL_W'(EPR) : rem[VL_W-1:0];
    nxt_last = ({1'b0, src_idx} == (src_n - 4'd1));
  end

  // Next-state logic for the IDLE/ISSUE controller.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = ISSUE;
      ISSUE:   if (fire & uop_last_q) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State register, latched instruction and registered uop fields.
  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      cnt_q      <= 3'd0;
      base_a_q   <= 5'd0;
      base_b_q   <= 5'd0;
      base_d_q   <= 5'd0;
      n_q        <= 4'd0;
      vl_q       <= '0;
      illegal_q  <= 1'b0;
      uop_a_q    <= 5'd0;
      uop_b_q    <= 5'd0;
      uop_d_q    <= 5'd0;
      uop_idx_q  <= 3'd0;
      uop_vl_q   <= '0;
      uop_last_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      illegal_q <= accept & (lmul_illegal | misalign);
      if (start || (fire && !uop_last_q)) begin
        if (start) begin
          base_a_q <= raA;
          base_b_q <= raB;
          base_d_q <= rdest;
          n_q      <= n_calc;
          vl_q     <= vl;
        end
        cnt_q      <= src_idx;
        uop_a_q    <= src_a + {2'b00, src_idx};
        uop_b_q    <= src_b + {2'b00, src_idx};
        uop_d_q    <= src_d + {2'b00, src_idx};
        uop_idx_q  <= src_idx;
        uop_vl_q   <= nxt_vl;
        uop_last_q <= nxt_last;
      end else if (fire && uop_last_q) begin
        cnt_q      <= 3'd0;
        uop_last_q <= 1'b0;
      end
    end
  end

  assign uop_valid  = busy;
  assign uop_raA    = uop_a_q;
  assign uop_raB    = uop_b_q;
  assign uop_rdest  = uop_d_q;
  assign uop_idx    = uop_idx_q;
  assign uop_vl     = uop_vl_q;
  assign uop_last   = uop_last_q;
  assign illegal_op = illegal_q;

endmodule
